// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Latency: n/a (types, constants and a pure helper only).
// Backpressure: n/a.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_t;

    localparam int DEF_CLIENTS   = 4;
    localparam int DEF_MAX_BURST = 16;

    // Increment modulo n, used to move the round-robin pointer past the last owner.
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_picker.sv
// Round-robin picker: first requester found scanning upward from ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a pick is consumed.
module RoundRobinPicker #(
    parameter int CLIENTS = 4,
    parameter int IDX_W   = $clog2(CLIENTS)
) (
    input  logic [CLIENTS-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [CLIENTS-1:0] winner,
    output logic [IDX_W-1:0]   index,
    output logic               any
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        winner   = '0;
        index    = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < CLIENTS; i++) begin
            cand     = (int'(ptr) + i) % CLIENTS;
            cand_idx = IDX_W'(cand);
            if (!any && req[cand_idx]) begin
                any              = 1'b1;
                winner[cand_idx] = 1'b1;
                index            = cand_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter granting one client at a time access to a single UART transmitter.
// Latency: grant 1 cycle after request in IDLE; start/ack 1 cycle after owner valid with UART idle.
// Backpressure: holds the owner in SEND while UartBusy_i is high; waits for UartDone_i per byte.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int CLIENTS   = DEF_CLIENTS,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [CLIENTS-1:0]   Req_i,
    input  logic [CLIENTS-1:0]   Valid_i,
    input  logic [CLIENTS-1:0]   Last_i,
    input  logic [8*CLIENTS-1:0] Data_i,
    output logic [CLIENTS-1:0]   Grant_o,
    output logic [CLIENTS-1:0]   Ack_o,
    output logic                 UartStart_o,
    output logic [7:0]           UartData_o,
    input  logic                 UartBusy_i,
    input  logic                 UartDone_i,
    output logic                 Busy_o
);

    localparam int IDX_W = $clog2(CLIENTS);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t         state_q, state_nxt;
    logic [IDX_W-1:0]   ptr_q, ptr_nxt;
    logic [IDX_W-1:0]   owner_q, owner_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic               last_q, last_nxt;
    logic [CLIENTS-1:0] grant_q, grant_nxt;
    logic [CLIENTS-1:0] ack_q, ack_nxt;
    logic               start_q, start_nxt;
    logic [7:0]         data_q, data_nxt;
    logic               busy_q, busy_nxt;
    logic               release_now;

    logic [CLIENTS-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    logic [7:0] client_byte [CLIENTS];

    for (genvar k = 0; k < CLIENTS; k++) begin : g_bytes
        assign client_byte[k] = Data_i[8*k +: 8];
    end

    RoundRobinPicker #(
        .CLIENTS (CLIENTS),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req    (Req_i),
        .ptr    (ptr_q),
        .winner (pick_oh),
        .index  (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        state_nxt   = state_q;
        ptr_nxt     = ptr_q;
        owner_nxt   = owner_q;
        cnt_nxt     = cnt_q;
        last_nxt    = last_q;
        grant_nxt   = grant_q;
        ack_nxt     = '0;
        start_nxt   = 1'b0;
        data_nxt    = data_q;
        release_now = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_nxt = ST_SEND;
                    grant_nxt = pick_oh;
                    owner_nxt = pick_idx;
                end
            end
            ST_SEND: begin
                // A presented byte wins over a dropped request.
                if (Valid_i[owner_q] && !UartBusy_i) begin
                    state_nxt         = ST_WAIT;
                    data_nxt          = client_byte[owner_q];
                    last_nxt          = Last_i[owner_q];
                    cnt_nxt           = cnt_q + CNT_W'(1);
                    start_nxt         = 1'b1;
                    ack_nxt[owner_q]  = 1'b1;
                end else if (!Req_i[owner_q]) begin
                    release_now = 1'b1;
                end
            end
            ST_WAIT: begin
                if (UartDone_i) begin
                    if (last_q || cnt_q == CNT_W'(MAX_BURST)) begin
                        release_now = 1'b1;
                    end else begin
                        state_nxt = ST_SEND;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = '0;
            end
        endcase

        if (release_now) begin
            state_nxt = ST_IDLE;
            grant_nxt = '0;
            cnt_nxt   = '0;
            ptr_nxt   = IDX_W'(wrap_inc(int'(owner_q), CLIENTS));
        end

        busy_nxt = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            grant_q <= '0;
            ack_q   <= '0;
            start_q <= 1'b0;
            data_q  <= 8'h00;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            ptr_q   <= ptr_nxt;
            owner_q <= owner_nxt;
            cnt_q   <= cnt_nxt;
            last_q  <= last_nxt;
            grant_q <= grant_nxt;
            ack_q   <= ack_nxt;
            start_q <= start_nxt;
            data_q  <= data_nxt;
            busy_q  <= busy_nxt;
        end
    end

    assign Grant_o     = grant_q;
    assign Ack_o       = ack_q;
    assign UartStart_o = start_q;
    assign UartData_o  = data_q;
    assign Busy_o      = busy_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: UartTxArbiter

Interface
REQ-001 SHALL have parameter CLIENTS, default 4, number of requesters, legal range 2..8.
REQ-002 SHALL have parameter MAX_BURST, default 16, max bytes per grant, legal range 1..255.
REQ-003 SHALL have port Clock  in  1  system clock, all logic on rising edge.
REQ-004 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port Req_i  in  CLIENTS  client k wants the channel.
REQ-006 SHALL have port Valid_i  in  CLIENTS  client k presents a byte.
REQ-007 SHALL have port Last_i  in  CLIENTS  client k's byte is the last of its message.
REQ-008 SHALL have port Data_i  in  8*CLIENTS  client k byte at bits [8k+7:8k].
REQ-009 SHALL have port Grant_o  out  CLIENTS  one-hot (or zero) current owner.
REQ-010 SHALL have port Ack_o  out  CLIENTS  one-cycle pulse, owner's byte accepted.
REQ-011 SHALL have port UartStart_o  out  1  one-cycle start pulse to UART_TX.
REQ-012 SHALL have port UartData_o  out  8  byte to UART_TX, held until next start.
REQ-013 SHALL have port UartBusy_i  in  1  UART_TX busy.
REQ-014 SHALL have port UartDone_i  in  1  UART_TX one-cycle frame-complete pulse.
REQ-015 SHALL have port Busy_o  out  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement states IDLE, SEND, WAIT; all outputs registered.
REQ-017 IDLE: if any Req_i set, SHALL select winner by round-robin starting at pointer Ptr, wrapping, and enter SEND with Grant_o one-hot at the winner the next cycle.
REQ-018 Grant latency SHALL be exactly 1 cycle: Req_i at cycle t in IDLE -> Grant_o at t+1.
REQ-019 SEND: if Valid_i[owner]=1 and UartBusy_i=0, SHALL latch Data_i[owner] into UartData_o, latch Last_i[owner], increment burst count, and pulse UartStart_o and Ack_o[owner] together for exactly one cycle, entering WAIT that same cycle.
REQ-020 SEND: if Valid_i[owner]=0 and Req_i[owner]=0, SHALL release (Grant_o=0, go IDLE); Valid_i[owner]=1 takes precedence over Req_i[owner]=0.
REQ-021 SEND: other clients' Valid_i/Req_i SHALL be ignored.
REQ-022 WAIT: SHALL ignore all client inputs; on UartDone_i, release if latched Last=1 or count=MAX_BURST, else return to SEND.
REQ-023 On release, Ptr SHALL become (owner+1) mod CLIENTS, burst count SHALL clear, and at least one IDLE cycle with Grant_o=0 SHALL occur before the next grant.
REQ-024 A client still requesting after a MAX_BURST release SHALL re-arbitrate normally; it does not keep priority.
REQ-025 Burst counter width SHALL be clog2(MAX_BURST+1); it SHALL never exceed MAX_BURST.
REQ-026 UartDone_i outside WAIT SHALL be ignored.
REQ-027 Busy_o SHALL be 1 in SEND and WAIT, 0 in IDLE.

Reset
REQ-028 Reset=1 at a rising edge SHALL force IDLE, Ptr=0, count=0, Grant_o=0, Ack_o=0, UartStart_o=0, UartData_o=8'h00, Busy_o=0, regardless of state (including mid-frame WAIT).
REQ-029 First grant after reset SHALL favour client 0 when several request.

Structure
REQ-030 Shared package uart_arb_pkg SHALL hold the state encoding and default CLIENTS/MAX_BURST constants.
REQ-031 Round-robin selection SHALL be a combinational sub-module RoundRobinPicker (inputs Req, Ptr; outputs one-hot winner, index, any).

Verification
REQ-032 Reset, then Req_i=4'b0110 at t -> Grant_o=4'b0010 at t+1; after its release, Grant_o=4'b0100.
REQ-033 Client 0 sends "Hi" (8'h48, then 8'h69 with Last=1) -> two UartStart_o pulses with UartData_o 8'h48, 8'h69, two Ack_o[0] pulses, release after second UartDone_i.
REQ-034 MAX_BURST=2, client 1 sends 3 bytes while client 2 requests -> after 2 bytes grant moves to client 2, client 1 regranted afterward for byte 3.
REQ-035 UartBusy_i=1 in SEND with Valid_i set -> no UartStart_o until UartBusy_i falls, then start next cycle.
REQ-036 Owner drops Req_i and Valid_i in SEND -> Grant_o=0 and Busy_o=0 next cycle, no UartStart_o.
REQ-037 Reset asserted in WAIT -> all outputs at reset values next cycle; stray UartDone_i afterward causes no action.
